// File: rtl/scan_pkg.sv
// Shared types and constants for the pattern scanner: FSM state
// encoding, part-index encoding and default widths.
package scan_pkg;

  localparam int SYM_W_DEF  = 8;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Part index: 0 means "not scanning", 1..4 select a pattern symbol.
  localparam logic [2:0] PART_NONE = 3'd0;
  localparam logic [2:0] PART_1    = 3'd1;
  localparam logic [2:0] PART_2    = 3'd2;
  localparam logic [2:0] PART_3    = 3'd3;
  localparam logic [2:0] PART_4    = 3'd4;

endpackage

// File: rtl/part_compare.sv
// Combinational pattern-part selector: picks pattern symbol `part_i`
// (part 1 in the MSBs) and compares the captured symbol against it and
// against part 1 (the latter drives the overlap restart).
module part_compare
  import scan_pkg::*;
#(
  parameter int SYM_W = SYM_W_DEF
) (
  input  logic [4*SYM_W-1:0] pattern_i,
  input  logic [2:0]         part_i,
  input  logic [SYM_W-1:0]   sym_i,
  output logic               eq_o,
  output logic               eq_first_o
);

  logic [SYM_W-1:0] parts [4];
  logic [SYM_W-1:0] sel;

  // Slice the pattern word into its four symbols, part 1 first.
  for (genvar gi = 0; gi < 4; gi++) begin : g_part
    assign parts[gi] = pattern_i[(4-gi)*SYM_W-1 -: SYM_W];
  end

  // Select the symbol the scanner currently expects; out-of-range
  // indices fall back to part 1.
  always_comb begin
    sel = parts[0];
    case (part_i)
      PART_2:  sel = parts[1];
      PART_3:  sel = parts[2];
      PART_4:  sel = parts[3];
      default: sel = parts[0];
    endcase
  end

  assign eq_o       = (sym_i == sel);
  assign eq_first_o = (sym_i == parts[0]);

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Pattern scanner: reads symbols one at a time over a req/ack port and
// searches for a four-symbol pattern with overlap restart.
// Optional macro PATTERN_SCAN_MULTI_EN: keep scanning after a match and
// count matches on match_count (first match still reported by find).
module pattern_scan_ctrl
  import scan_pkg::*;
#(
  parameter int SYM_W  = SYM_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [ADDR_W-1:0]   stream_len,
  input  logic [4*SYM_W-1:0]  pattern,
  output logic                rd_req,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic                rd_ack,
  input  logic [SYM_W-1:0]    rd_data,
  output logic [2:0]          which_part,
  output logic                busy,
  output logic                done,
  output logic                find,
  output logic [ADDR_W-1:0]   match_addr
`ifdef PATTERN_SCAN_MULTI_EN
  ,
  output logic [ADDR_W-1:0]   match_count
`endif
);

  state_e             state_q, state_d;
  logic [2:0]         part_q, part_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  len_q, len_d;
  logic [4*SYM_W-1:0] pat_q, pat_d;
  logic [SYM_W-1:0]   sym_q, sym_d;
  logic               find_q, find_d;
  logic [ADDR_W-1:0]  match_addr_q, match_addr_d;
`ifdef PATTERN_SCAN_MULTI_EN
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
`endif

  logic eq, eq_first;
  logic last_sym, hit, end_scan;

  part_compare #(.SYM_W(SYM_W)) u_cmp (
    .pattern_i  (pat_q),
    .part_i     (part_q),
    .sym_i      (sym_q),
    .eq_o       (eq),
    .eq_first_o (eq_first)
  );

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      part_q       <= PART_1;
      addr_q       <= '0;
      len_q        <= '0;
      pat_q        <= '0;
      sym_q        <= '0;
      find_q       <= 1'b0;
      match_addr_q <= '0;
`ifdef PATTERN_SCAN_MULTI_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      part_q       <= part_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      pat_q        <= pat_d;
      sym_q        <= sym_d;
      find_q       <= find_d;
      match_addr_q <= match_addr_d;
`ifdef PATTERN_SCAN_MULTI_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d      = state_q;
    part_d       = part_q;
    addr_d       = addr_q;
    len_d        = len_q;
    pat_d        = pat_q;
    sym_d        = sym_q;
    find_d       = find_q;
    match_addr_d = match_addr_q;
`ifdef PATTERN_SCAN_MULTI_EN
    cnt_d        = cnt_q;
`endif
    rd_req     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    which_part = PART_NONE;
    last_sym   = (addr_q == len_q - ADDR_W'(1));
    hit        = eq && (part_q == PART_4);
    end_scan   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          find_d = 1'b0;
`ifdef PATTERN_SCAN_MULTI_EN
          cnt_d  = '0;
`endif
          if (stream_len != '0) begin
            pat_d        = pattern;
            len_d        = stream_len;
            match_addr_d = '0;
            addr_d       = '0;
            part_d       = PART_1;
            state_d      = REQ;
          end else begin
            state_d = DONE;
          end
        end
      end

      REQ: begin
        rd_req     = 1'b1;
        busy       = 1'b1;
        which_part = part_q;
        if (stop) begin
          state_d = DONE;
        end else if (rd_ack) begin
          sym_d   = rd_data;
          state_d = CHECK;
        end
      end

      CHECK: begin
        busy       = 1'b1;
        which_part = part_q;
        if (stop) begin
          state_d = DONE;
        end else begin
          if (hit) begin
            // Only the first match of a scan sets the reported address.
            if (!find_q) begin
              match_addr_d = addr_q - ADDR_W'(3);
            end
            find_d = 1'b1;
`ifdef PATTERN_SCAN_MULTI_EN
            part_d = PART_1;
            cnt_d  = cnt_q + ADDR_W'(1);
`endif
          end else if (eq) begin
            part_d = part_q + 3'd1;
          end else if (eq_first) begin
            // Mismatch that still starts a new candidate match.
            part_d = PART_2;
          end else begin
            part_d = PART_1;
          end
`ifdef PATTERN_SCAN_MULTI_EN
          end_scan = last_sym;
`else
          end_scan = last_sym || hit;
`endif
          if (end_scan) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = REQ;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign rd_addr    = addr_q;
  assign find       = find_q;
  assign match_addr = match_addr_q;
`ifdef PATTERN_SCAN_MULTI_EN
  assign match_count = cnt_q;
`endif

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl: scripted scans against a small
// symbol memory with a configurable-latency acknowledge model.
module tb_pattern_scan_ctrl;
  import scan_pkg::*;

  localparam int SW = 8;
  localparam int AW = 8;
  localparam logic [31:0] PAT_ABCD = 32'h41424344;

  logic          clock = 1'b0;
  logic          reset, start, stop;
  logic [AW-1:0] stream_len;
  logic [4*SW-1:0] pattern;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic [SW-1:0] rd_data;
  logic [2:0]    which_part;
  logic          busy, done, find;
  logic [AW-1:0] match_addr;
`ifdef PATTERN_SCAN_MULTI_EN
  logic [AW-1:0] match_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [SW-1:0] mem [256];
  int ack_delay = 0;
  int wait_cnt  = 0;

  int cyc, req_seen, done_cnt, req_after_done;
  logic [31:0] parts_pk;

  pattern_scan_ctrl #(.SYM_W(SW), .ADDR_W(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .stream_len (stream_len),
    .pattern    (pattern),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_ack     (rd_ack),
    .rd_data    (rd_data),
    .which_part (which_part),
    .busy       (busy),
    .done       (done),
    .find       (find),
    .match_addr (match_addr)
`ifdef PATTERN_SCAN_MULTI_EN
    ,
    .match_count(match_count)
`endif
  );

  always #5 clock = ~clock;

  // Memory responder: acknowledges after ack_delay waiting REQ cycles.
  assign rd_ack  = rd_req && (wait_cnt >= ack_delay);
  assign rd_data = mem[rd_addr];
  always @(posedge clock) wait_cnt <= (rd_req && !rd_ack) ? wait_cnt + 1 : 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input string s);
    for (int i = 0; i < s.len(); i++) mem[i] = s[i];
  endtask

  // Start a scan and follow it to its done pulse, recording which_part
  // in each CHECK cycle (three bits per check, oldest first).
  task automatic run_scan(input string name, input logic [31:0] pat, input int len,
                          input int max_cyc);
    pattern    = pat;
    stream_len = len[AW-1:0];
    start      = 1'b1;
    tick();
    start          = 1'b0;
    cyc            = 1;
    parts_pk       = '0;
    req_seen       = 0;
    done_cnt       = 0;
    req_after_done = 0;
    while (!done && cyc < max_cyc) begin
      if (rd_req) req_seen++;
      if (busy && !rd_req) parts_pk = (parts_pk << 3) | 32'(which_part);
      tick();
      cyc++;
    end
    check({name, "_done_seen"}, 32'(done), 32'd1);
    if (done) done_cnt = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) done_cnt++;
      if (rd_req) req_after_done++;
    end
    $display("scan %s len=%0d: find=%0d match_addr=%0d cycles=%0d parts=%0o",
             name, len, find, match_addr, cyc, parts_pk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    stream_len = '0; pattern = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    tick(); tick();
    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_find", 32'(find), 32'd0);
    check("rst_match_addr", 32'(match_addr), 32'd0);
    check("rst_which_part", 32'(which_part), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    reset = 1'b0;
    tick();

    // Match in the middle of the stream, ack in the first REQ cycle.
    load("xABCDx");
    run_scan("xABCDx", PAT_ABCD, 6, 60);
    check("s1_find", 32'(find), 32'd1);
    check("s1_match_addr", 32'(match_addr), 32'd1);
    check("s1_done_pulses", 32'(done_cnt), 32'd1);
`ifdef PATTERN_SCAN_MULTI_EN
    check("s1_cycles", 32'(cyc), 32'd13);
    check("s1_parts", parts_pk, 32'o112341);
`else
    check("s1_cycles", 32'(cyc), 32'd11);
    check("s1_parts", parts_pk, 32'o11234);
`endif

    // Zero-length scan: straight to DONE, no reads, find cleared.
    run_scan("len0", PAT_ABCD, 0, 10);
    check("s2_cycles", 32'(cyc), 32'd1);
    check("s2_req_seen", 32'(req_seen), 32'd0);
    check("s2_req_after", 32'(req_after_done), 32'd0);
    check("s2_find", 32'(find), 32'd0);
    check("s2_done_pulses", 32'(done_cnt), 32'd1);

    // Overlap restart: second A takes part to 2.
    load("AABCD");
    run_scan("AABCD", PAT_ABCD, 5, 60);
    check("s3_find", 32'(find), 32'd1);
    check("s3_match_addr", 32'(match_addr), 32'd1);
    check("s3_parts", parts_pk, 32'o12234);
    check("s3_cycles", 32'(cyc), 32'd11);

    // No match: full-length scan, match_addr cleared by start.
    load("ABCABD");
    run_scan("ABCABD", PAT_ABCD, 6, 60);
    check("s4_find", 32'(find), 32'd0);
    check("s4_match_addr", 32'(match_addr), 32'd0);
    check("s4_cycles", 32'(cyc), 32'd13);
    check("s4_parts", parts_pk, 32'o123423);
    check("s4_req_after", 32'(req_after_done), 32'd0);
    check("s4_done_pulses", 32'(done_cnt), 32'd1);

    // Abort in REQ while the ack is still pending.
    load("ABCD");
    ack_delay  = 3;
    pattern    = PAT_ABCD;
    stream_len = 8'd4;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("s5_pre_req", 32'(rd_req), 32'd1);
    stop = 1'b1; tick(); stop = 1'b0;
    check("s5_rd_req", 32'(rd_req), 32'd0);
    check("s5_done", 32'(done), 32'd1);
    check("s5_busy", 32'(busy), 32'd0);
    check("s5_which_part", 32'(which_part), 32'd0);
    tick();
    check("s5_done_once", 32'(done), 32'd0);
    $display("stop with pending ack: aborted to DONE");

    // Abort in REQ with an ack present: stop wins over the ack.
    ack_delay = 0;
    start = 1'b1; tick(); start = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    check("s5b_busy", 32'(busy), 32'd0);
    check("s5b_done", 32'(done), 32'd1);
    tick();
    $display("stop with ack present: aborted to DONE");

    // Reset in the middle of a scan, while in CHECK.
    load("xxABCD");
    pattern    = PAT_ABCD;
    stream_len = 8'd6;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    check("s6_in_check", 32'(busy && !rd_req), 32'd1);
    reset = 1'b1; tick();
    check("s6_rd_req", 32'(rd_req), 32'd0);
    check("s6_busy", 32'(busy), 32'd0);
    check("s6_done", 32'(done), 32'd0);
    check("s6_find", 32'(find), 32'd0);
    check("s6_match_addr", 32'(match_addr), 32'd0);
    check("s6_which_part", 32'(which_part), 32'd0);
    check("s6_rd_addr", 32'(rd_addr), 32'd0);
`ifdef PATTERN_SCAN_MULTI_EN
    check("s6_match_count", 32'(match_count), 32'd0);
`endif
    reset = 1'b0; tick();
    check("s6_idle_after", 32'(busy | rd_req), 32'd0);
    $display("reset during CHECK: outputs back at reset values");

    // Two back-to-back matches.
    load("ABCDABCD");
    run_scan("ABCDABCD", PAT_ABCD, 8, 80);
    check("s7_find", 32'(find), 32'd1);
    check("s7_match_addr", 32'(match_addr), 32'd0);
`ifdef PATTERN_SCAN_MULTI_EN
    check("s7_match_count", 32'(match_count), 32'd2);
    check("s7_cycles", 32'(cyc), 32'd17);
`else
    check("s7_cycles", 32'(cyc), 32'd9);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
